// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises instruction-fetch and data accesses onto one memory
//            port with data priority and a bounded data streak; drives stall.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int MAX_D_STREAK = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [WIDTH-1:0]     i_addr,
    output logic                 i_ack,
    output logic [WIDTH-1:0]     i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WIDTH-1:0]     d_addr,
    input  logic [WIDTH-1:0]     d_wdata,
    input  logic [WIDTH/8-1:0]   d_be,
    output logic                 d_ack,
    output logic [WIDTH-1:0]     d_rdata,
    output logic                 m_req,
    output logic                 m_we,
    output logic [WIDTH-1:0]     m_addr,
    output logic [WIDTH-1:0]     m_wdata,
    output logic [WIDTH/8-1:0]   m_be,
    input  logic                 m_gnt,
    input  logic                 m_rvalid,
    input  logic [WIDTH-1:0]     m_rdata,
    output logic                 stall
);

    localparam int                    c_BE_W       = WIDTH / 8;
    localparam int                    c_STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_RD = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    logic [1:0]            r_state_q,   w_state_d;
    logic                  r_owner_q,   w_owner_d;
    logic [c_STREAK_W-1:0] r_streak_q,  w_streak_d;
    logic                  r_m_req_q,   w_m_req_d;
    logic                  r_m_we_q,    w_m_we_d;
    logic [WIDTH-1:0]      r_m_addr_q,  w_m_addr_d;
    logic [WIDTH-1:0]      r_m_wdata_q, w_m_wdata_d;
    logic [c_BE_W-1:0]     r_m_be_q,    w_m_be_d;
    logic                  r_i_ack_q,   w_i_ack_d;
    logic                  r_d_ack_q,   w_d_ack_d;
    logic [WIDTH-1:0]      r_i_rdata_q, w_i_rdata_d;
    logic [WIDTH-1:0]      r_d_rdata_q, w_d_rdata_d;
    logic                  w_grant_d;
    logic                  w_grant_i;

    always_comb begin
        w_state_d   = r_state_q;
        w_owner_d   = r_owner_q;
        w_streak_d  = r_streak_q;
        w_m_req_d   = r_m_req_q;
        w_m_we_d    = r_m_we_q;
        w_m_addr_d  = r_m_addr_q;
        w_m_wdata_d = r_m_wdata_q;
        w_m_be_d    = r_m_be_q;
        w_i_ack_d   = 1'b0;
        w_d_ack_d   = 1'b0;
        w_i_rdata_d = r_i_rdata_q;
        w_d_rdata_d = r_d_rdata_q;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                // Data wins unless the waiting fetch has already been passed over MAX_D_STREAK times
                w_grant_d = d_req && !(i_req && (r_streak_q == c_STREAK_MAX));
                w_grant_i = !w_grant_d && i_req;
                if (w_grant_d) begin
                    w_owner_d   = c_OWN_D;
                    w_m_req_d   = 1'b1;
                    w_m_we_d    = d_we;
                    w_m_addr_d  = d_addr;
                    w_m_wdata_d = d_wdata;
                    w_m_be_d    = d_be;
                    w_state_d   = c_ST_ISSUE;
                    if (i_req && (r_streak_q != c_STREAK_MAX)) begin
                        w_streak_d = r_streak_q + c_STREAK_ONE;
                    end
                end else if (w_grant_i) begin
                    w_owner_d   = c_OWN_I;
                    w_m_req_d   = 1'b1;
                    w_m_we_d    = 1'b0;
                    w_m_addr_d  = i_addr;
                    w_m_wdata_d = '0;
                    w_m_be_d    = '1;
                    w_streak_d  = '0;
                    w_state_d   = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (m_gnt) begin
                    w_m_req_d = 1'b0;
                    if (r_m_we_q) begin
                        // Stores complete on acceptance; the ack is raised entering RESP
                        w_state_d = c_ST_RESP;
                        w_i_ack_d = (r_owner_q == c_OWN_I);
                        w_d_ack_d = (r_owner_q == c_OWN_D);
                    end else begin
                        w_state_d = c_ST_WAIT_RD;
                    end
                end
            end
            c_ST_WAIT_RD: begin
                if (m_rvalid) begin
                    w_state_d = c_ST_RESP;
                    if (r_owner_q == c_OWN_D) begin
                        w_d_rdata_d = m_rdata;
                        w_d_ack_d   = 1'b1;
                    end else begin
                        w_i_rdata_d = m_rdata;
                        w_i_ack_d   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q   <= c_ST_IDLE;
            r_owner_q   <= c_OWN_I;
            r_streak_q  <= '0;
            r_m_req_q   <= 1'b0;
            r_m_we_q    <= 1'b0;
            r_m_addr_q  <= '0;
            r_m_wdata_q <= '0;
            r_m_be_q    <= '0;
            r_i_ack_q   <= 1'b0;
            r_d_ack_q   <= 1'b0;
            r_i_rdata_q <= '0;
            r_d_rdata_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_owner_q   <= w_owner_d;
            r_streak_q  <= w_streak_d;
            r_m_req_q   <= w_m_req_d;
            r_m_we_q    <= w_m_we_d;
            r_m_addr_q  <= w_m_addr_d;
            r_m_wdata_q <= w_m_wdata_d;
            r_m_be_q    <= w_m_be_d;
            r_i_ack_q   <= w_i_ack_d;
            r_d_ack_q   <= w_d_ack_d;
            r_i_rdata_q <= w_i_rdata_d;
            r_d_rdata_q <= w_d_rdata_d;
        end
    end

    assign m_req   = r_m_req_q;
    assign m_we    = r_m_we_q;
    assign m_addr  = r_m_addr_q;
    assign m_wdata = r_m_wdata_q;
    assign m_be    = r_m_be_q;
    assign i_ack   = r_i_ack_q;
    assign d_ack   = r_d_ack_q;
    assign i_rdata = r_i_rdata_q;
    assign d_rdata = r_d_rdata_q;
    assign stall   = (i_req & ~r_i_ack_q) | (d_req & ~r_d_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomised cycle-level bench for mem_arbiter against a
//            transaction-level model with its own memory and requesters.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_MAXS   = 3;
    localparam int c_N_CYC  = 3000;
    localparam int c_PHASE1 = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_gnt = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        stall;

    mem_arbiter #(.WIDTH(32), .MAX_D_STREAK(c_MAXS)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Transaction-level model state
    logic [31:0] mem [16];
    bit          busy, own_d, is_wr, rst_low_prev, do_rst, phase1, e_iack, e_dack, e_mreq;
    int          streak, free_at, t_grant, t_gnt, t_rv, t_ack, stale_at, i_gap, d_gap;
    logic [31:0] exp_m_addr, exp_m_wdata, exp_i_rdata, exp_d_rdata, rv_data;
    logic        exp_m_we;
    logic [3:0]  exp_m_be;

    function automatic logic [31:0] rand_addr();
        return ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = rand_addr();
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom();
        d_be    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = $urandom();
        busy = 0; streak = 0; free_at = 0; stale_at = -1; i_gap = 0; d_gap = 0;
        t_grant = -10; t_gnt = -10; t_rv = -10; t_ack = -10;
        rv_data = '0;
        repeat (2) @(posedge clk);
        rst_low_prev = 1'b1;

        for (cyc = 0; cyc < c_N_CYC; cyc++) begin
            @(negedge clk);
            phase1 = (cyc < c_PHASE1);

            if (rst_low_prev) begin
                busy = 0; streak = 0; free_at = cyc;
                exp_m_we = 1'b0; exp_m_addr = '0; exp_m_wdata = '0; exp_m_be = '0;
                exp_i_rdata = '0; exp_d_rdata = '0;
            end

            e_iack = busy && !own_d && (cyc == t_ack);
            e_dack = busy &&  own_d && (cyc == t_ack);
            e_mreq = busy && (cyc > t_grant) && (cyc <= t_gnt);
            if ((e_iack || e_dack) && !is_wr) begin
                if (own_d) exp_d_rdata = rv_data;
                else       exp_i_rdata = rv_data;
            end

            check("m_req",   32'(m_req),   32'(e_mreq));
            check("m_we",    32'(m_we),    32'(exp_m_we));
            check("m_addr",  m_addr,       exp_m_addr);
            check("m_wdata", m_wdata,      exp_m_wdata);
            check("m_be",    32'(m_be),    32'(exp_m_be));
            check("i_ack",   32'(i_ack),   32'(e_iack));
            check("d_ack",   32'(d_ack),   32'(e_dack));
            check("i_rdata", i_rdata,      exp_i_rdata);
            check("d_rdata", d_rdata,      exp_d_rdata);

            if (e_iack || e_dack) busy = 0;

            // Resets land mostly while a read is waiting for its data beat
            do_rst = !phase1 &&
                     ((busy && !is_wr && (cyc > t_gnt) && (cyc < t_rv) && ($urandom_range(0, 7) == 0)) ||
                      ($urandom_range(0, 199) == 0));
            rst = !do_rst;

            if (do_rst) begin
                i_req = 1'b0; d_req = 1'b0;
                i_gap = $urandom_range(0, 3); d_gap = $urandom_range(0, 3);
                stale_at = cyc + 3;
            end else begin
                if (e_iack) begin i_req = 1'b0; i_gap = phase1 ? 0 : $urandom_range(0, 3); end
                if (e_dack) begin d_req = 1'b0; d_gap = phase1 ? 0 : $urandom_range(0, 3); end
                if (!i_req) begin if (i_gap == 0) new_i(); else i_gap--; end
                if (!d_req) begin if (d_gap == 0) new_d(); else d_gap--; end
            end

            if (!do_rst && !busy && (cyc >= free_at) && (i_req || d_req)) begin
                if (d_req && !(i_req && (streak == c_MAXS))) begin
                    own_d = 1; is_wr = d_we;
                    exp_m_we = d_we; exp_m_addr = d_addr; exp_m_wdata = d_wdata; exp_m_be = d_be;
                    if (i_req && (streak < c_MAXS)) streak++;
                end else begin
                    own_d = 0; is_wr = 0;
                    exp_m_we = 1'b0; exp_m_addr = i_addr; exp_m_wdata = '0; exp_m_be = 4'hF;
                    streak = 0;
                end
                t_grant = cyc;
                t_gnt   = cyc + 1 + (phase1 ? 0 : int'($urandom_range(0, 3)));
                t_rv    = t_gnt + 1 + (phase1 ? 0 : int'($urandom_range(0, 3)));
                t_ack   = is_wr ? t_gnt + 1 : t_rv + 1;
                free_at = t_ack + 1;
                busy    = 1;
            end

            // Memory responder; spurious strobes only where the spec says they are ignored
            if (busy && (cyc > t_grant) && (cyc <= t_gnt)) begin
                m_gnt = (cyc == t_gnt);
                if ((cyc == t_gnt) && is_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (exp_m_be[b]) mem[exp_m_addr[5:2]][8*b +: 8] = exp_m_wdata[8*b +: 8];
                end
            end else begin
                m_gnt = !phase1 && ($urandom_range(0, 3) == 0);
            end

            if (busy && !is_wr && (cyc > t_gnt) && (cyc <= t_rv)) begin
                m_rvalid = (cyc == t_rv);
                if (cyc == t_rv) rv_data = mem[exp_m_addr[5:2]];
                m_rdata = (cyc == t_rv) ? rv_data : $urandom();
            end else begin
                m_rvalid = (cyc == stale_at) || (!phase1 && ($urandom_range(0, 5) == 0));
                m_rdata  = $urandom();
            end

            rst_low_prev = do_rst;
            #1;
            check("stall", 32'(stall), 32'((i_req & ~e_iack) | (d_req & ~e_dack)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter and sequencer that lets the core's instruction-fetch port and data load/store port share a single unified memory with variable grant and read latency. It sits between the core datapath (PC/fetch side and ALU-address/data side) and the backing memory. It serialises accesses one at a time, with data-over-fetch priority and starvation protection. It also produces the stall the core uses to freeze the PC and register writeback.

## Interface
Parameters:
- WIDTH, 32, data and address width
- MAX_D_STREAK, 3, consecutive data grants allowed while a fetch waits; must be ≥1

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  WIDTH  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  WIDTH  fetched instruction, registered
- d_req  in  1  data request; held with d_we, d_addr, d_wdata and d_be stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  WIDTH  data address
- d_wdata  in  WIDTH  store data
- d_be  in  WIDTH/8  store byte enables
- d_ack  out  1  one-cycle pulse: data access complete, d_rdata valid for loads
- d_rdata  out  WIDTH  load data, registered
- m_req  out  1  memory request, registered
- m_we  out  1  memory write
- m_addr  out  WIDTH  memory address
- m_wdata  out  WIDTH  memory write data
- m_be  out  WIDTH/8  memory byte enables
- m_gnt  in  1  memory accepts the request this cycle
- m_rvalid  in  1  read data valid this cycle
- m_rdata  in  WIDTH  read data
- stall  out  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack)

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP. An owner register (I or D) records the port being served. Only one transaction is outstanding at any time.
- IDLE:
  - If d_req is high and not (i_req and streak == MAX_D_STREAK): grant D.
  - Otherwise, if i_req is high: grant I.
  - On a grant: latch the owner, load the m_* fields, go to ISSUE.
- Fields loaded for a fetch: m_we=0, m_be all ones, m_addr=i_addr, m_wdata=0.
- Fields loaded for a data access: m_we, m_addr, m_wdata and m_be come from the d_* inputs.
- Streak counter:
  - Saturating, width $clog2(MAX_D_STREAK+1).
  - Increments on a D grant while i_req is high.
  - Clears on any I grant.
  - Holds on a D grant while i_req is low.
- ISSUE: m_req=1 with all m_* fields held stable until m_gnt.
  - On m_gnt with m_we=1: go to RESP.
  - On m_gnt with m_we=0: go to WAIT_RD.
- WAIT_RD: m_req=0. On m_rvalid, capture m_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ack for one cycle, then return to IDLE. The rdata register keeps its value until the next read completes on that port.
- A requester still asserting req in the cycle after its ack is treated as a new request.
- m_rvalid outside WAIT_RD is ignored. m_gnt is ignored while m_req is low.
- Non-owner requests wait; their inputs are not sampled until they are granted.

## Timing
- Reset (rst low at an edge): state=IDLE, streak=0. All registered outputs read 0 from the next cycle: m_req, m_we, m_addr, m_wdata, m_be, i_ack, d_ack, i_rdata, d_rdata.
- Reset mid-transaction: the transaction is abandoned and no ack is produced. A stale m_rvalid arriving after reset is ignored.
- Request sampled in IDLE at cycle 0: m_req is high in cycle 1.
- Zero-wait memory (m_gnt in cycle 1, m_rvalid in cycle 2):
  - Store: ack in cycle 2.
  - Load or fetch: ack in cycle 3.
- Each cycle of m_gnt delay and each cycle of m_rvalid delay adds one cycle to the ack.
- Back-to-back service: after RESP, the next grant is evaluated in the following IDLE cycle. Minimum spacing between two loads is 4 cycles.
- Simultaneous i_req and d_req in IDLE: D wins unless streak == MAX_D_STREAK.

## Test plan
- Single fetch, zero-wait memory: i_req with i_addr=0x100, m_rdata=0x00500093 → m_req in cycle 1 with m_addr=0x100, m_be=4'hF, m_we=0; i_ack in cycle 3 with i_rdata=0x00500093; stall high in cycles 0–2.
- Store with 2-cycle grant delay: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, d_be=4'b0011 → m_* fields stable across the stalled ISSUE cycles; d_ack exactly one cycle after m_gnt; i_ack stays low.
- Contention and starvation: i_req and d_req held continuously, each completing in zero-wait → grant order D, D, D, I, D, D, D, I …; with MAX_D_STREAK=1 → D, I, D, I.
- Load with m_rvalid delayed by 3 cycles, plus a spurious m_rvalid while in IDLE → d_rdata updates only from the valid beat; the spurious beat causes no ack and no rdata change.
- Reset in WAIT_RD, with m_rvalid arriving 2 cycles after rst is released → no ack; all outputs 0; the next request is served normally.
- Requester holds req after ack → a second access starts in the IDLE cycle after RESP, with a second one-cycle ack pulse.
